// File: rtl/morse_pkg.sv
// morse_pkg
// Shared definitions for the Morse transmit path: FSM state type, timing
// unit counts for each keying phase, the word-space code, and the A..Z
// element table (also used by the receive side).
package morse_pkg;

  typedef enum logic [2:0] {IDLE, MARK, GAP, LGAP, SPACE} tx_state_t;

  // Phase lengths in Morse units
  localparam logic [2:0] DOT_U    = 3'd1;
  localparam logic [2:0] DASH_U   = 3'd3;
  localparam logic [2:0] EGAP_U   = 3'd1;
  localparam logic [2:0] LGAP_U   = 3'd3;
  localparam logic [2:0] WSPACE_U = 3'd7;

  localparam logic [4:0] CODE_SPACE = 5'd26;

  // Returns {len[2:0], pat[3:0]}. pat is MSB-first, 1 = dash, unused
  // low bits are zero. Codes outside 0..25 return all zeros.
  function automatic logic [6:0] morse_lookup(input logic [4:0] letter);
    logic [6:0] code;
    code = 7'd0;
    case (letter)
      5'd0:  code = {3'd2, 4'b0100}; // A .-
      5'd1:  code = {3'd4, 4'b1000}; // B -...
      5'd2:  code = {3'd4, 4'b1010}; // C -.-.
      5'd3:  code = {3'd3, 4'b1000}; // D -..
      5'd4:  code = {3'd1, 4'b0000}; // E .
      5'd5:  code = {3'd4, 4'b0010}; // F ..-.
      5'd6:  code = {3'd3, 4'b1100}; // G --.
      5'd7:  code = {3'd4, 4'b0000}; // H ....
      5'd8:  code = {3'd2, 4'b0000}; // I ..
      5'd9:  code = {3'd4, 4'b0111}; // J .---
      5'd10: code = {3'd3, 4'b1010}; // K -.-
      5'd11: code = {3'd4, 4'b0100}; // L .-..
      5'd12: code = {3'd2, 4'b1100}; // M --
      5'd13: code = {3'd2, 4'b1000}; // N -.
      5'd14: code = {3'd3, 4'b1110}; // O ---
      5'd15: code = {3'd4, 4'b0110}; // P .--.
      5'd16: code = {3'd4, 4'b1101}; // Q --.-
      5'd17: code = {3'd3, 4'b0100}; // R .-.
      5'd18: code = {3'd3, 4'b0000}; // S ...
      5'd19: code = {3'd1, 4'b1000}; // T -
      5'd20: code = {3'd3, 4'b0010}; // U ..-
      5'd21: code = {3'd4, 4'b0001}; // V ...-
      5'd22: code = {3'd3, 4'b0110}; // W .--
      5'd23: code = {3'd4, 4'b1001}; // X -..-
      5'd24: code = {3'd4, 4'b1011}; // Y -.--
      5'd25: code = {3'd4, 4'b1100}; // Z --..
      default: code = 7'd0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/morse_transmitter_unit_timer.sv
// unit_timer
// Counts cycles of the current keying phase and flags its last cycle.
// Ports:
//   Clock   - system clock (posedge)
//   Reset   - synchronous active-low reset
//   restart - reload the count to 0 (asserted on every phase entry)
//   units   - length of the current phase in Morse units (0 = no phase)
//   expire  - high during the last cycle of a units*DOT_TICKS period
module unit_timer #(
  parameter int DOT_TICKS = 25_000_000,
  parameter int CNT_W     = $clog2(DOT_TICKS*7+1)
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       restart,
  input  logic [2:0] units,
  output logic       expire
);

  logic [CNT_W-1:0] cnt_reg;
  logic [31:0]      span;
  logic [CNT_W-1:0] limit;

  always_comb begin
    span  = 32'(units) * 32'(DOT_TICKS);
    limit = CNT_W'(span - 32'd1);
  end

  // units==0 means no timed phase is running, so never expire
  assign expire = (units != 3'd0) && (cnt_reg == limit);

  always_ff @(posedge Clock) begin
    if (!Reset || restart) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/morse_transmitter.sv
// morse_transmitter
// Keys out one Morse character per accepted request on key_out.
// Ports:
//   Clock   - system clock (posedge)
//   Reset   - synchronous active-low reset
//   letter  - 0..25 = A..Z, 26 = word space, 27..31 = illegal
//   valid   - request strobe, accepted when valid && ready
//   ready   - idle and able to accept a letter
//   key_out - keying output, 1 = tone/LED on
//   done    - one-cycle pulse when a character and its trailing gap finish
//   err     - one-cycle pulse when an illegal code is accepted
module morse_transmitter
  import morse_pkg::*;
#(
  parameter int DOT_TICKS = 25_000_000,
  parameter int CNT_W     = $clog2(DOT_TICKS*7+1)
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [4:0] letter,
  input  logic       valid,
  output logic       ready,
  output logic       key_out,
  output logic       done,
  output logic       err
);

  tx_state_t  state_reg;
  logic [2:0] len_reg;
  logic [3:0] pat_reg;
  logic [1:0] idx_reg;
  logic       key_out_reg;
  logic       done_reg;
  logic       err_reg;
  logic       ready_reg;

  logic [2:0] units_next;
  logic       restart;
  logic       expire;
  logic       accept;
  logic       last_elem;
  logic [6:0] lookup;

  assign accept    = valid && ready_reg;
  assign lookup    = morse_lookup(letter);
  assign last_elem = ({1'b0, idx_reg} == (len_reg - 3'd1));

  // Length of the phase currently running
  always_comb begin
    units_next = 3'd0;
    case (state_reg)
      MARK:    units_next = pat_reg[2'd3 - idx_reg] ? DASH_U : DOT_U;
      GAP:     units_next = EGAP_U;
      LGAP:    units_next = LGAP_U;
      SPACE:   units_next = WSPACE_U;
      default: units_next = 3'd0;
    endcase
  end

  // Every phase end is also the entry into the next state, and the count
  // is held at zero while idle, so the first cycle of any phase sees cnt=0.
  assign restart = (state_reg == IDLE) || expire;

  unit_timer #(
    .DOT_TICKS(DOT_TICKS),
    .CNT_W    (CNT_W)
  ) u_timer (
    .Clock  (Clock),
    .Reset  (Reset),
    .restart(restart),
    .units  (units_next),
    .expire (expire)
  );

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_reg   <= IDLE;
      len_reg     <= 3'd0;
      pat_reg     <= 4'd0;
      idx_reg     <= 2'd0;
      key_out_reg <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      ready_reg   <= 1'b1;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (letter < CODE_SPACE) begin
              {len_reg, pat_reg} <= lookup;
              idx_reg     <= 2'd0;
              key_out_reg <= 1'b1;
              ready_reg   <= 1'b0;
              state_reg   <= MARK;
            end else if (letter == CODE_SPACE) begin
              ready_reg <= 1'b0;
              state_reg <= SPACE;
            end else begin
              // Illegal code: flag it and stay ready
              err_reg <= 1'b1;
            end
          end
        end
        MARK: begin
          if (expire) begin
            key_out_reg <= 1'b0;
            if (last_elem) begin
              state_reg <= LGAP;
            end else begin
              idx_reg   <= idx_reg + 2'd1;
              state_reg <= GAP;
            end
          end
        end
        GAP: begin
          if (expire) begin
            key_out_reg <= 1'b1;
            state_reg   <= MARK;
          end
        end
        LGAP, SPACE: begin
          if (expire) begin
            done_reg  <= 1'b1;
            ready_reg <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: begin
          key_out_reg <= 1'b0;
          ready_reg   <= 1'b1;
          state_reg   <= IDLE;
        end
      endcase
    end
  end

  assign ready   = ready_reg;
  assign key_out = key_out_reg;
  assign done    = done_reg;
  assign err     = err_reg;

endmodule

// File: tb/tb_morse_transmitter.sv
// tb_morse_transmitter
// Drives the transmitter with directed and random letters and compares
// {key_out, ready, done, err} every cycle against a trace built from the
// textual Morse table and the unit timing rules.
module tb_morse_transmitter;

  localparam int DOT = 2;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic [4:0] letter = 5'd0;
  logic       valid = 1'b0;
  logic       ready;
  logic       key_out;
  logic       done;
  logic       err;

  int checks   = 0;
  int failures = 0;

  // Expected {key_out, ready, done, err} per cycle after acceptance
  logic [3:0] exp_q[$];

  string morse_tab[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.",
                           "....", "..", ".---", "-.-", ".-..", "--", "-.",
                           "---", ".--.", "--.-", ".-.", "...", "-", "..-",
                           "...-", ".--", "-..-", "-.--", "--.."};

  morse_transmitter #(.DOT_TICKS(DOT)) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .letter (letter),
    .valid  (valid),
    .ready  (ready),
    .key_out(key_out),
    .done   (done),
    .err    (err)
  );

  always #5 Clock = ~Clock;

  // Behavioural model: append the expected per-cycle trace for one request
  task automatic model_char(input int code);
    string s;
    int    u;
    if (code < 26) begin
      s = morse_tab[code];
      for (int e = 0; e < s.len(); e++) begin
        u = (s[e] == "-") ? 3 : 1;
        repeat (u * DOT) exp_q.push_back(4'b1000);
        if (e != s.len() - 1) repeat (DOT) exp_q.push_back(4'b0000);
      end
      repeat (3 * DOT) exp_q.push_back(4'b0000);
      exp_q.push_back(4'b0110);
    end else if (code == 26) begin
      repeat (7 * DOT) exp_q.push_back(4'b0000);
      exp_q.push_back(4'b0110);
    end else begin
      exp_q.push_back(4'b0101);
    end
  endtask

  task automatic test_reset();
    logic [3:0] obs;
    Reset = 1'b0;
    valid = 1'b1;
    letter = 5'd4;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clock);
      obs = {key_out, ready, done, err};
      checks++;
      if (obs !== 4'b0100) begin
        failures++;
        $display("FAIL reset_hold cyc%0d: got key/rdy/done/err=%b expected %b", i, obs, 4'b0100);
      end
    end
    Reset = 1'b1;
    valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      obs = {key_out, ready, done, err};
      checks++;
      if (obs !== 4'b0100) begin
        failures++;
        $display("FAIL reset_release cyc%0d: got key/rdy/done/err=%b expected %b", i, obs, 4'b0100);
      end
    end
  endtask

  task automatic test_letters();
    int codes[$];
    int code;
    int idle;
    logic [3:0] obs;
    logic [3:0] expv;
    codes = '{4, 0};
    for (int i = 0; i < 8; i++) codes.push_back(int'($urandom_range(0, 26)));
    foreach (codes[k]) begin
      code = codes[k];
      exp_q.delete();
      model_char(code);
      valid = 1'b1;
      letter = 5'(code);
      @(posedge Clock);
      #1 valid = 1'b0;
      for (int i = 0; exp_q.size() > 0; i++) begin
        @(negedge Clock);
        obs = {key_out, ready, done, err};
        expv = exp_q.pop_front();
        checks++;
        if (obs !== expv) begin
          failures++;
          $display("FAIL letter%0d cyc%0d: got key/rdy/done/err=%b expected %b", code, i + 1, obs, expv);
        end
      end
      $display("letter %0d transmitted", code);
      idle = int'($urandom_range(0, 2));
      repeat (idle) begin
        @(negedge Clock);
        obs = {key_out, ready, done, err};
        checks++;
        if (obs !== 4'b0100) begin
          failures++;
          $display("FAIL idle_after%0d: got key/rdy/done/err=%b expected %b", code, obs, 4'b0100);
        end
      end
    end
  endtask

  task automatic test_space_illegal();
    int codes[2] = '{26, 30};
    logic [3:0] obs;
    logic [3:0] expv;
    foreach (codes[k]) begin
      exp_q.delete();
      model_char(codes[k]);
      // Illegal codes must leave the line idle afterwards
      repeat (2) exp_q.push_back(4'b0100);
      valid = 1'b1;
      letter = 5'(codes[k]);
      @(posedge Clock);
      #1 valid = 1'b0;
      for (int i = 0; exp_q.size() > 0; i++) begin
        @(negedge Clock);
        obs = {key_out, ready, done, err};
        expv = exp_q.pop_front();
        checks++;
        if (obs !== expv) begin
          failures++;
          $display("FAIL code%0d cyc%0d: got key/rdy/done/err=%b expected %b", codes[k], i + 1, obs, expv);
        end
      end
      $display("code %0d handled", codes[k]);
    end
  endtask

  task automatic test_back_to_back();
    int n_first;
    logic [3:0] obs;
    logic [3:0] expv;
    exp_q.delete();
    model_char(19);
    n_first = exp_q.size();
    model_char(4);
    valid = 1'b1;
    letter = 5'd19;
    @(posedge Clock);
    #1 letter = 5'd4;
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge Clock);
      obs = {key_out, ready, done, err};
      expv = exp_q.pop_front();
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL back_to_back cyc%0d: got key/rdy/done/err=%b expected %b", i + 1, obs, expv);
      end
      if (i == n_first - 1) begin
        // E is taken on the edge closing T's done cycle
        @(posedge Clock);
        #1 valid = 1'b0;
      end
    end
    $display("back-to-back T,E transmitted");
  endtask

  task automatic test_reset_mid();
    logic [3:0] obs;
    logic [3:0] expv;
    valid = 1'b1;
    letter = 5'd19;
    @(posedge Clock);
    #1 valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      obs = {key_out, ready, done, err};
      checks++;
      if (obs !== 4'b1000) begin
        failures++;
        $display("FAIL mid_dash cyc%0d: got key/rdy/done/err=%b expected %b", i + 1, obs, 4'b1000);
      end
    end
    Reset = 1'b0;
    @(negedge Clock);
    obs = {key_out, ready, done, err};
    checks++;
    if (obs !== 4'b0100) begin
      failures++;
      $display("FAIL mid_reset: got key/rdy/done/err=%b expected %b", obs, 4'b0100);
    end
    Reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clock);
      obs = {key_out, ready, done, err};
      checks++;
      if (obs !== 4'b0100) begin
        failures++;
        $display("FAIL post_reset_idle cyc%0d: got key/rdy/done/err=%b expected %b", i, obs, 4'b0100);
      end
    end
    exp_q.delete();
    model_char(4);
    valid = 1'b1;
    letter = 5'd4;
    @(posedge Clock);
    #1 valid = 1'b0;
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge Clock);
      obs = {key_out, ready, done, err};
      expv = exp_q.pop_front();
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL fresh_e cyc%0d: got key/rdy/done/err=%b expected %b", i + 1, obs, expv);
      end
    end
    $display("reset mid-dash recovered, E transmitted");
  endtask

  initial begin
    test_reset();
    test_letters();
    test_space_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
